usb_rx_pkt_parse: RTL and testbench

- Sits directly downstream of the USB receive front end: consumes its PID, byte stream and CRC-status outputs and turns each packet into decoded events.
- Token packets (OUT/IN/SETUP) yield address/endpoint with an address-match flag; SOF packets yield the frame number; handshakes yield their PID.
- Data packets are forwarded byte by byte with the two CRC16 bytes stripped, then terminated by an end pulse carrying good/bad status.

---
 rtl/usb_pkg.sv | 37 +++
 rtl/usb_crc_strip.sv | 75 +++++++
 rtl/usb_rx_pkt_parse.sv | 170 +++++++++++++++++
 tb/tb_usb_rx_pkt_parse.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB packet definitions: PID codes and the
// receive-parser state encoding.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_DATA,
    ST_HSHK,
    ST_DISCARD
  } state_t;

  // Which parser state a freshly received PID leads to.
  function automatic state_t pid_class(input logic [3:0] pid);
    state_t s;
    case (pid)
      PID_OUT, PID_IN,
      PID_SETUP, PID_SOF:  s = ST_TOKEN;
      PID_DATA0, PID_DATA1: s = ST_DATA;
      PID_ACK, PID_NAK,
      PID_STALL:           s = ST_HSHK;
      default:             s = ST_DISCARD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/usb_crc_strip.sv
// Two-byte delay line that hides the trailing CRC16 of
// a data packet, with byte count and payload overflow.
module usb_crc_strip #(
  parameter int MAX_PAYLOAD = 64,
  parameter int CW = $clog2(MAX_PAYLOAD + 4)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          strobe,
  input  logic          pass,
  input  logic [7:0]    din,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt,
  output logic          ovf_nxt,
  output logic [7:0]    dout,
  output logic          dout_valid
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PAYLOAD + 3);
  localparam logic [CW-1:0] PAY_END = CW'(MAX_PAYLOAD + 2);
  localparam logic [CW-1:0] TWO     = CW'(2);

  logic [7:0] old_b;
  logic [7:0] new_b;
  logic       ovf;
  logic       emit;
  logic       keep;

  // A byte leaves the line only once two newer ones exist;
  // bytes past the payload limit are dropped as overflow.
  assign emit = strobe & pass & ~clr & (cnt >= TWO);
  assign keep = emit & (cnt < PAY_END);

  // Next count / overflow, also used at packet end.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (clr) begin
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else begin
      if (strobe && cnt != CNT_MAX)
        cnt_nxt = cnt + CW'(1);
      if (emit && !keep)
        ovf_nxt = 1'b1;
    end
  end

  // Delay line shift and registered byte output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      ovf        <= 1'b0;
      old_b      <= '0;
      new_b      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      ovf        <= ovf_nxt;
      dout_valid <= keep;
      if (keep)
        dout <= old_b;
      if (clr) begin
        old_b <= '0;
        new_b <= '0;
      end else if (strobe) begin
        old_b <= new_b;
        new_b <= din;
      end
    end
  end

endmodule

// File: rtl/usb_rx_pkt_parse.sv
// USB receive packet parser: tokens, SOF, handshakes
// and CRC-stripped data payload events.
module usb_rx_pkt_parse
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  dev_addr,
  input  logic [3:0]  xpid,
  input  logic        xpacket,
  input  logic [7:0]  xdata,
  input  logic        xdatastrobe,
  input  logic        xcrc5_ok,
  input  logic        xcrc16_ok,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [3:0]  tok_ep,
  output logic        tok_match,
  output logic        sof_valid,
  output logic [10:0] sof_frame,
  output logic        hs_valid,
  output logic [3:0]  hs_pid,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        data_pid1,
  output logic        data_end,
  output logic        data_ok,
  output logic        data_err
);

  localparam int CW = $clog2(MAX_PAYLOAD + 4);

  state_t        state;
  logic          xpacket_q;
  logic          armed;
  logic [3:0]    pid_r;
  logic [7:0]    byte0_r;
  logic [2:0]    byte1_r;
  logic          crc5_r;
  logic          crc16_r;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_nxt;
  logic          start;
  logic          pkt_end;
  logic          crc5_e;
  logic          crc16_e;
  logic [7:0]    b0_e;
  logic [2:0]    b1_e;
  logic          tok_good;
  logic          hs_good;
  logic          data_good;

  // A packet already in flight when reset lifts is not
  // a start; wait for the bus to go idle first.
  assign start   = xpacket & ~xpacket_q & armed;
  assign pkt_end = ~xpacket & xpacket_q;

  // A byte arriving with the end still counts.
  assign crc5_e  = xdatastrobe ? xcrc5_ok  : crc5_r;
  assign crc16_e = xdatastrobe ? xcrc16_ok : crc16_r;
  assign b0_e = (xdatastrobe && cnt == CW'(0))
              ? xdata : byte0_r;
  assign b1_e = (xdatastrobe && cnt == CW'(1))
              ? xdata[2:0] : byte1_r;

  assign tok_good  = (cnt_nxt == CW'(2)) & crc5_e;
  assign hs_good   = (cnt_nxt == CW'(0));
  assign data_good = crc16_e & (cnt_nxt >= CW'(2))
                   & ~ovf_nxt;

  usb_crc_strip #(
    .MAX_PAYLOAD (MAX_PAYLOAD),
    .CW          (CW)
  ) u_strip (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start),
    .strobe     (xdatastrobe),
    .pass       (state == ST_DATA),
    .din        (xdata),
    .cnt        (cnt),
    .cnt_nxt    (cnt_nxt),
    .ovf_nxt    (ovf_nxt),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // Packet FSM with registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      xpacket_q <= 1'b0;
      armed     <= 1'b0;
      pid_r     <= '0;
      byte0_r   <= '0;
      byte1_r   <= '0;
      crc5_r    <= 1'b0;
      crc16_r   <= 1'b0;
      tok_valid <= 1'b0;
      tok_pid   <= '0;
      tok_ep    <= '0;
      tok_match <= 1'b0;
      sof_valid <= 1'b0;
      sof_frame <= '0;
      hs_valid  <= 1'b0;
      hs_pid    <= '0;
      data_pid1 <= 1'b0;
      data_end  <= 1'b0;
      data_ok   <= 1'b0;
      data_err  <= 1'b0;
    end else begin
      xpacket_q <= xpacket;
      if (!xpacket)
        armed <= 1'b1;
      tok_valid <= 1'b0;
      sof_valid <= 1'b0;
      hs_valid  <= 1'b0;
      data_end  <= 1'b0;
      data_ok   <= 1'b0;
      data_err  <= 1'b0;
      if (xdatastrobe) begin
        crc5_r  <= xcrc5_ok;
        crc16_r <= xcrc16_ok;
        byte0_r <= b0_e;
        byte1_r <= b1_e;
      end
      unique case (1'b1)
        start: begin
          state <= pid_class(xpid);
          pid_r <= xpid;
          if (pid_class(xpid) == ST_DATA)
            data_pid1 <= xpid[3];
        end
        pkt_end: begin
          state <= ST_IDLE;
          case (state)
            ST_TOKEN: begin
              if (tok_good && pid_r == PID_SOF) begin
                sof_valid <= 1'b1;
                sof_frame <= {b1_e, b0_e};
              end else if (tok_good) begin
                tok_valid <= 1'b1;
                tok_pid   <= pid_r;
                tok_ep    <= {b1_e, b0_e[7]};
                tok_match <= (b0_e[6:0] == dev_addr);
              end
            end
            ST_HSHK: begin
              if (hs_good) begin
                hs_valid <= 1'b1;
                hs_pid   <= pid_r;
              end
            end
            ST_DATA: begin
              data_end <= 1'b1;
              data_ok  <= data_good;
              data_err <= ~data_good;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_parse.sv
// Bench for usb_rx_pkt_parse: directed and random packets
// checked against a per-packet reference model.
module tb_usb_rx_pkt_parse;

  localparam int MAXP = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  dev_addr = '0;
  logic [3:0]  xpid = '0;
  logic        xpacket = 1'b0;
  logic [7:0]  xdata = '0;
  logic        xdatastrobe = 1'b0;
  logic        xcrc5_ok = 1'b0;
  logic        xcrc16_ok = 1'b0;
  logic        tok_valid;
  logic [3:0]  tok_pid;
  logic [3:0]  tok_ep;
  logic        tok_match;
  logic        sof_valid;
  logic [10:0] sof_frame;
  logic        hs_valid;
  logic [3:0]  hs_pid;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        data_pid1;
  logic        data_end;
  logic        data_ok;
  logic        data_err;

  usb_rx_pkt_parse #(.MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .dev_addr(dev_addr),
    .xpid(xpid), .xpacket(xpacket), .xdata(xdata),
    .xdatastrobe(xdatastrobe), .xcrc5_ok(xcrc5_ok),
    .xcrc16_ok(xcrc16_ok), .tok_valid(tok_valid),
    .tok_pid(tok_pid), .tok_ep(tok_ep),
    .tok_match(tok_match), .sof_valid(sof_valid),
    .sof_frame(sof_frame), .hs_valid(hs_valid),
    .hs_pid(hs_pid), .dout(dout), .dout_valid(dout_valid),
    .data_pid1(data_pid1), .data_end(data_end),
    .data_ok(data_ok), .data_err(data_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int end_cyc = 0;
  logic [7:0] pb [0:127];
  int sc [0:127];
  logic cur_pid1 = 1'b0;

  // observed
  int n_tok = 0, n_sof = 0, n_hs = 0, n_end = 0;
  int n_ok = 0, n_err = 0, pid1_bad = 0;
  logic [7:0] dq_o [$];
  int dc_o [$];
  int ev_o [$];

  // expected
  int e_tok = 0, e_sof = 0, e_hs = 0, e_end = 0;
  int e_ok = 0, e_err = 0;
  logic [3:0]  e_tpid = '0;
  logic [3:0]  e_tep = '0;
  logic        e_tmatch = 1'b0;
  logic [10:0] e_frame = '0;
  logic [3:0]  e_hspid = '0;
  logic [7:0] dq_e [$];
  int dc_e [$];
  int ev_e [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tok_valid) n_tok++;
    if (sof_valid) n_sof++;
    if (hs_valid) n_hs++;
    if (data_end) begin
      n_end++;
      if (data_ok) n_ok++;
      if (data_err) n_err++;
    end
    if (tok_valid | sof_valid | hs_valid | data_end)
      ev_o.push_back(cyc);
    if (dout_valid) begin
      dq_o.push_back(dout);
      dc_o.push_back(cyc);
    end
    if ((dout_valid | data_end) && data_pid1 !== cur_pid1)
      pid1_bad++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {24'h0, tok_valid, tok_pid, tok_ep, tok_match,
            sof_valid, sof_frame, hs_valid, hs_pid, dout,
            dout_valid, data_pid1, data_end, data_ok,
            data_err};
  endfunction

  // Reference: what one whole packet should produce.
  task automatic model(input logic [3:0] pid, input int n,
                       input bit ok);
    int pay, em;
    bit dok;
    case (pid)
      4'b0001, 4'b1001, 4'b1101, 4'b0101: begin
        if (n == 2 && ok) begin
          ev_e.push_back(end_cyc + 1);
          if (pid == 4'b0101) begin
            e_sof++;
            e_frame = 11'((pb[1] & 8'h07) * 256 + pb[0]);
          end else begin
            e_tok++;
            e_tpid = pid;
            e_tep = 4'((pb[1] & 8'h07) * 2 + pb[0][7]);
            e_tmatch = ((pb[0] & 8'h7f) == {1'b0, dev_addr});
          end
        end
      end
      4'b0011, 4'b1011: begin
        pay = (n >= 2) ? n - 2 : 0;
        em = (pay > MAXP) ? MAXP : pay;
        dok = ok && n >= 2 && pay <= MAXP;
        e_end++;
        if (dok) e_ok++; else e_err++;
        for (int i = 0; i < em; i++) begin
          dq_e.push_back(pb[i]);
          dc_e.push_back(sc[i + 2] + 1);
        end
        ev_e.push_back(end_cyc + 1);
      end
      4'b0010, 4'b1010, 4'b1110: begin
        if (n == 0) begin
          e_hs++;
          e_hspid = pid;
          ev_e.push_back(end_cyc + 1);
        end
      end
      default: ;
    endcase
  endtask

  // Drive one packet; called at posedge+1 with bus idle.
  // ok is the CRC status of the final byte, earlier bytes
  // carry the opposite status.
  task automatic send(input logic [3:0] pid, input int n,
                      input bit ok, input bit merge,
                      input int tail);
    if (pid == 4'b0011 || pid == 4'b1011)
      cur_pid1 = pid[3];
    xpacket = 1'b1;
    xpid = pid;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      xdatastrobe = 1'b0;
      @(posedge clk); #1;
      xdatastrobe = 1'b1;
      xdata = pb[i];
      xcrc5_ok = (i == n - 1) ? ok : ~ok;
      xcrc16_ok = (i == n - 1) ? ok : ~ok;
      sc[i] = cyc;
      if (i == n - 1 && merge) begin
        xpacket = 1'b0;
        end_cyc = cyc;
      end
    end
    if (!(n > 0 && merge)) begin
      @(posedge clk); #1;
      xdatastrobe = 1'b0;
      xpacket = 1'b0;
      end_cyc = cyc;
    end
    for (int t = 0; t < tail; t++) begin
      @(posedge clk); #1;
      xdatastrobe = 1'b0;
    end
    model(pid, n, ok);
  endtask

  task automatic check_all(input string tag);
    int bad;
    chk({tag, ".n_tok"}, n_tok, e_tok);
    chk({tag, ".n_sof"}, n_sof, e_sof);
    chk({tag, ".n_hs"}, n_hs, e_hs);
    chk({tag, ".n_end"}, n_end, e_end);
    chk({tag, ".n_ok"}, n_ok, e_ok);
    chk({tag, ".n_err"}, n_err, e_err);
    chk({tag, ".tok_pid"}, tok_pid, e_tpid);
    chk({tag, ".tok_ep"}, tok_ep, e_tep);
    chk({tag, ".tok_match"}, tok_match, e_tmatch);
    chk({tag, ".sof_frame"}, sof_frame, e_frame);
    chk({tag, ".hs_pid"}, hs_pid, e_hspid);
    chk({tag, ".pid1_bad"}, pid1_bad, 0);
    chk({tag, ".dout_len"}, dq_o.size(), dq_e.size());
    chk({tag, ".ev_len"}, ev_o.size(), ev_e.size());
    bad = 0;
    foreach (dq_e[i])
      if (i < dq_o.size() &&
          (dq_o[i] !== dq_e[i] || dc_o[i] != dc_e[i]))
        bad++;
    chk({tag, ".dout_data"}, bad, 0);
    bad = 0;
    foreach (ev_e[i])
      if (i < ev_o.size() && ev_o[i] != ev_e[i])
        bad++;
    chk({tag, ".ev_cycle"}, bad, 0);
    dq_o.delete(); dc_o.delete(); ev_o.delete();
    dq_e.delete(); dc_e.delete(); ev_e.delete();
  endtask

  logic [3:0] pids [0:8] = '{4'b0001, 4'b1001, 4'b1101,
                             4'b0101, 4'b0011, 4'b1011,
                             4'b0010, 4'b1010, 4'b1110};

  initial begin
    logic [3:0] rp;
    int rn;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_outs", all_outs(), 64'h0);

    // IN token, addr 5 ep 3
    dev_addr = 7'd5;
    pb[0] = 8'h85; pb[1] = 8'h01;
    send(4'b1001, 2, 1'b1, 1'b0, 3);
    check_all("in_match");
    chk("in_ep_direct", tok_ep, 4'd3);
    dev_addr = 7'd6;
    send(4'b1001, 2, 1'b1, 1'b0, 3);
    check_all("in_nomatch");
    chk("in_match_direct", tok_match, 1'b0);

    // SOF good then bad
    pb[0] = 8'h2A; pb[1] = 8'h05;
    send(4'b0101, 2, 1'b1, 1'b0, 3);
    check_all("sof_good");
    chk("sof_frame_direct", sof_frame, 11'h52A);
    pb[0] = 8'h11; pb[1] = 8'h03;
    send(4'b0101, 2, 1'b0, 1'b0, 3);
    check_all("sof_bad");

    // DATA1 11 22 33 + CRC
    pb[0] = 8'h11; pb[1] = 8'h22; pb[2] = 8'h33;
    pb[3] = 8'hA5; pb[4] = 8'h5A;
    send(4'b1011, 5, 1'b1, 1'b0, 3);
    check_all("data1_3");

    // short and zero-length DATA0
    send(4'b0011, 1, 1'b1, 1'b0, 3);
    check_all("data0_short");
    send(4'b0011, 2, 1'b1, 1'b0, 3);
    check_all("data0_zlp");

    // overflow: MAXP+1 payload bytes
    for (int i = 0; i < MAXP + 3; i++)
      pb[i] = 8'($urandom);
    send(4'b0011, MAXP + 3, 1'b1, 1'b0, 3);
    check_all("data0_ovf");

    // handshakes
    send(4'b0010, 0, 1'b1, 1'b0, 3);
    check_all("ack0");
    send(4'b0010, 1, 1'b1, 1'b0, 3);
    check_all("ack1");

    // last byte together with end
    dev_addr = 7'h33;
    pb[0] = 8'hB3; pb[1] = 8'h06;
    send(4'b1101, 2, 1'b1, 1'b1, 3);
    check_all("setup_merge");
    pb[0] = 8'hC1; pb[1] = 8'hC2;
    pb[2] = 8'h00; pb[3] = 8'hFF;
    send(4'b1011, 4, 1'b1, 1'b1, 3);
    check_all("data1_merge");

    // next start while previous pulse issues
    pb[0] = 8'h07; pb[1] = 8'h02;
    send(4'b0001, 2, 1'b1, 1'b0, 1);
    send(4'b1010, 0, 1'b1, 1'b0, 3);
    check_all("b2b");

    // reset in the middle of a DATA0 packet
    cur_pid1 = 1'b0;
    xpacket = 1'b1;
    xpid = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      xdatastrobe = 1'b0;
      @(posedge clk); #1;
      xdatastrobe = 1'b1;
      xdata = 8'h40 + 8'(i);
      xcrc16_ok = 1'b1;
    end
    @(posedge clk); #1;
    xdatastrobe = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", all_outs(), 64'h0);
    e_tpid = '0; e_tep = '0; e_tmatch = 1'b0;
    e_frame = '0; e_hspid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      xdatastrobe = 1'b0;
      @(posedge clk); #1;
      xdatastrobe = 1'b1;
      xdata = 8'h50 + 8'(i);
    end
    @(posedge clk); #1;
    xdatastrobe = 1'b0;
    xpacket = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("midreset_quiet");
    pb[0] = 8'h9A; pb[1] = 8'hBC; pb[2] = 8'hDE;
    pb[3] = 8'h01; pb[4] = 8'h02;
    send(4'b0011, 5, 1'b1, 1'b0, 3);
    check_all("after_reset");

    // random packets
    for (int k = 0; k < 40; k++) begin
      rp = ($urandom % 4 == 0) ? 4'($urandom)
         : pids[$urandom_range(0, 8)];
      rn = ($urandom % 2 == 0) ? 2 : $urandom_range(0, 7);
      for (int i = 0; i < rn; i++)
        pb[i] = 8'($urandom);
      dev_addr = ($urandom % 2 == 0) ? pb[0][6:0]
               : 7'($urandom);
      send(rp, rn, ($urandom % 4) != 0,
           rn > 0 && ($urandom % 2 == 0),
           2 + int'($urandom % 2));
      check_all($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
